// File: rtl/geometry_animator_if.sv
// Bundles the frame-sync inputs and the animated geometry outputs of geometry_animator.
interface geometry_animator_if;
    logic        vsync;
    logic        run;
    logic [59:0] geometry;
    logic        busy;
    logic [3:0]  frame;

    modport master (
        output vsync,
        output run,
        input  geometry,
        input  busy,
        input  frame
    );

    modport slave (
        input  vsync,
        input  run,
        output geometry,
        output busy,
        output frame
    );
endinterface

// File: rtl/geometry_animator.sv
// Per-frame triangle vertex animator: steps six coordinates by signed velocities,
// reflects them at the screen bounds, and publishes all six in one cycle.
module geometry_animator #(
    parameter logic [9:0]  X_MAX     = 10'd639,
    parameter logic [9:0]  Y_MAX     = 10'd479,
    parameter logic [59:0] INIT_GEOM = {10'd100, 10'd1, 10'd1, 10'd100, 10'd200, 10'd200},
    parameter logic [23:0] INIT_VEL  = {4'h3, 4'hE, 4'h1, 4'h2, 4'hD, 4'h1}
) (
    input  logic               clk,
    input  logic               reset,
    geometry_animator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        COMMIT
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               vsync_d_q, vsync_d_d;
    logic [59:0]        geom_q, geom_d;
    logic [3:0]         frame_q, frame_d;
    logic [9:0]         shadow_q [0:5];
    logic [9:0]         shadow_d [0:5];
    logic signed [3:0]  vel_q [0:5];
    logic signed [3:0]  vel_d [0:5];

    logic [9:0]         cur_pos;
    logic signed [3:0]  cur_vel;
    logic signed [11:0] pos_ext;
    logic signed [11:0] vel_ext;
    logic signed [11:0] sum;
    logic signed [11:0] bound;
    logic               tick;

    // State, shadow and live registers; reset restores the configured geometry and velocities.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            vsync_d_q <= 1'b1;
            geom_q    <= INIT_GEOM;
            frame_q   <= '0;
            for (int unsigned k = 0; k < 6; k++) begin
                shadow_q[k] <= INIT_GEOM[59 - 10*k -: 10];
                vel_q[k]    <= INIT_VEL[23 - 4*k -: 4];
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            vsync_d_q <= vsync_d_d;
            geom_q    <= geom_d;
            frame_q   <= frame_d;
            for (int unsigned k = 0; k < 6; k++) begin
                shadow_q[k] <= shadow_d[k];
                vel_q[k]    <= vel_d[k];
            end
        end
    end

    // Next-state logic: one coordinate stepped per UPDATE cycle, all six published in COMMIT.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        vsync_d_d = bus.vsync;
        geom_d    = geom_q;
        frame_d   = frame_q;
        shadow_d  = shadow_q;
        vel_d     = vel_q;

        tick    = bus.vsync && !vsync_d_q;
        cur_pos = shadow_q[idx_q];
        cur_vel = vel_q[idx_q];
        pos_ext = {2'b00, cur_pos};
        vel_ext = {{8{cur_vel[3]}}, cur_vel};
        sum     = pos_ext + vel_ext;
        bound   = idx_q[0] ? {2'b00, Y_MAX} : {2'b00, X_MAX};

        case (state_q)
            IDLE: begin
                if (tick && bus.run) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                // Reflect at either bound; an out-of-range start value is clamped here too.
                if (sum < 12'sd0) begin
                    shadow_d[idx_q] = '0;
                    vel_d[idx_q]    = -cur_vel;
                end else if (sum > bound) begin
                    shadow_d[idx_q] = bound[9:0];
                    vel_d[idx_q]    = -cur_vel;
                end else begin
                    shadow_d[idx_q] = sum[9:0];
                end
                if (idx_q == 3'd5) begin
                    state_d = COMMIT;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            COMMIT: begin
                geom_d  = {shadow_q[0], shadow_q[1], shadow_q[2],
                           shadow_q[3], shadow_q[4], shadow_q[5]};
                frame_d = frame_q + 4'd1;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.geometry = geom_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.frame    = frame_q;

endmodule

// File: doc/geometry_animator.md
# geometry_animator

Per-frame vertex animation stage that sits directly upstream of the triangle scan stage and replaces its constant geometry input. Once per frame, on the rising edge of `vsync`, it steps each of the six triangle coordinates by a signed per-coordinate velocity and reflects at the screen bounds. It then commits all six results to `geometry` in a single cycle, so the scan stage never sees a half-updated triangle. It also provides the frame counter that the top level uses for colour selection.

## Interface
- `X_MAX`, 639, inclusive upper bound for x coordinates (10-bit).
- `Y_MAX`, 479, inclusive upper bound for y coordinates (10-bit).
- `INIT_GEOM`, {10'd100,10'd1,10'd1,10'd100,10'd200,10'd200}, 60-bit reset geometry.
- `INIT_VEL`, {4'sd3,-4'sd2,4'sd1,4'sd2,-4'sd3,4'sd1}, 24-bit; six signed 4-bit velocities in the same order as the coordinates. The legal range is -7..7; -8 is illegal.
- `clk` input 1: single clock (pixel clock).
- `reset` input 1: asynchronous, active-high reset.
- `vsync` input 1: vertical sync from `hvsync_generator`, synchronous to `clk`.
- `run` input 1: when high, animation proceeds; when low, geometry is frozen.
- `geometry` output 60: packed {x0,y0,x1,y1,x2,y2}, with x0 at [59:50] and y2 at [9:0].
- `busy` output 1: high while an update is in progress.
- `frame` output 4: count of committed updates, wraps 15→0.

## Operation
- Frame tick: registered `vsync_d`; a tick occurs when `vsync`=1 and `vsync_d`=0. A tick is accepted only in IDLE with `run`=1. Otherwise it is dropped, not queued.
- State machine:
  - IDLE: on an accepted tick, go to UPDATE with idx=0.
  - UPDATE: processes coordinate idx (0..5), one per cycle. idx=5 goes to COMMIT; otherwise idx increments.
  - COMMIT: copies the shadow registers to `geometry`, increments `frame`, and returns to IDLE.
- Coordinate order is idx 0..5 = x0,y0,x1,y1,x2,y2. Even idx use bound `X_MAX`; odd idx use bound `Y_MAX`.
- Arithmetic per coordinate: `sum` = zero-extended 10-bit position plus sign-extended 4-bit velocity, evaluated as 12-bit signed.
  - If `sum` < 0: shadow pos = 0, vel = -vel.
  - If `sum` > bound: shadow pos = bound, vel = -vel.
  - Otherwise: shadow pos = `sum`[9:0], vel unchanged.
- Velocity 0 leaves the coordinate fixed. Negating a value in -7..7 never produces -8.
- The shadow registers and the live velocity registers update in UPDATE. `geometry` changes only in COMMIT.
- A position already beyond its bound (for example, a bad `INIT_GEOM`) is clamped to the bound on the first update.
- `busy` = (state != IDLE).

## Timing
- Reset values (applied asynchronously, immediately):
  - `geometry` = `INIT_GEOM`, shadow = `INIT_GEOM`, velocities = `INIT_VEL`.
  - state IDLE, idx 0, `busy` 0, `frame` 0.
  - `vsync_d` = 1, so a `vsync` that is already high at reset release does not produce a tick.
- Edge numbering: call the edge that samples the tick edge 0. That edge enters UPDATE.
  - Edges 1..6 write shadow idx 0..5.
  - Edge 7 is COMMIT: `geometry` and `frame` are updated and the state returns to IDLE.
  - Total latency from tick to new `geometry` is 7 clocks after edge 0.
- `busy` is high from after edge 0 until after edge 7 (7 cycles).
- A tick during `busy` is ignored. `vsync` held high produces exactly one tick.
- Changing `run` mid-update does not abort the update; the update completes.
- Reset asserted mid-update discards the shadow contents and restores all reset values; no partial commit occurs.

## Test plan
- Reset: assert `reset` without a clock → `geometry`=`INIT_GEOM`, `busy`=0, `frame`=0. Release `reset` while `vsync`=1 → no update occurs.
- One tick with defaults → after edge 7, x0=103, y0=0 (1-2 clamped, vel becomes +2), x1=2, y1=102, x2=197, y2=201, `frame`=1. Second tick → y0=2.
- Upper bound: `INIT_GEOM` x0=638 with vel +3 → first tick x0=639 (vel becomes -3); second tick x0=636. Same check for y at `Y_MAX`=479.
- Atomicity: monitor `geometry` every cycle during a tick → it is constant for edges 0..6 and all six fields change together at edge 7. `busy` is high for exactly 7 cycles.
- Drops: pulse `vsync` again while `busy` → `frame` increments once. Hold `vsync` high for 1000 cycles → one update only. Set `run`=0 and apply 3 ticks → `geometry` and `frame` unchanged.
- Mid-update reset: assert `reset` at edge 3 → `geometry`=`INIT_GEOM`, `busy`=0 immediately. The next tick then gives the same result as scenario 2.
